// File: rtl/snake_pkg.sv
// Shared types and constants for the two-snake LED game.
// State encodings, LED geometry, reset and wall bitmaps.
package snake_pkg;

  localparam int LED_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LED_W-1:0] A_RST  = 16'hE000;
  localparam logic [LED_W-1:0] B_RST  = 16'h0001;
  // A snake touching one of these bits cannot go further that way.
  localparam logic [LED_W-1:0] WALL_R = 16'h0001;
  localparam logic [LED_W-1:0] WALL_L = 16'h8000;

  localparam logic [1:0] MODE_RST = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;

  // dir=1 moves toward bit 15 (left/up), dir=0 toward bit 0.
  function automatic logic [LED_W-1:0] shift_pos(
    input logic [LED_W-1:0] p,
    input logic             left
  );
    return left ? (p << 1) : (p >> 1);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Free-running prescaler with three step ticks.
// Ports: clk, rst, clear, run in; tick[j] = tick_(BASE+j) out.
module snake_tick_gen #(
  parameter int BASE = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  output logic [2:0] tick
);

  logic [BASE+1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= cnt + 1'b1;
  end

  for (genvar j = 0; j < 3; j++) begin : g_tick
    assign tick[j] = run && (&cnt[BASE+j-1:0]);
  end

endmodule

// File: rtl/snake_step_scheduler.sv
// Two-snake step scheduler: ticks, arbitration, bounces, round timer, FSM.
// Ports: clk, rst, start, speed_up, speed_down in; led, state, mode_a, hits, time_left out.
module snake_step_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_BASE_LOG2 = 24,
  parameter int ROUND_TICKS    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             speed_up,
  input  logic             speed_down,
  output logic [LED_W-1:0] led,
  output logic [1:0]       state,
  output logic [1:0]       mode_a,
  output logic [3:0]       hits,
  output logic [3:0]       time_left
);

  localparam logic [3:0] TIME_RST = 4'(ROUND_TICKS);

  state_t state_q, state_d;
  logic clr_pre, reinit, run;
  logic [2:0] tick;
  logic tick_a, req_a, req_b, slow;
  logic pend_a, pend_b, prio_a, gnt_a, gnt_b;
  logic [LED_W-1:0] pos_a, pos_b, pos_a_d, pos_b_d, led_q;
  logic dir_a, dir_b, dir_a_d, dir_b_d;
  logic [LED_W-1:0] cur, oth, tgt, nxt;
  logic cur_dir, wall, clash, nxt_dir;
  logic [1:0] mode_q;
  logic [3:0] hits_q, time_q;

  snake_tick_gen #(
    .BASE(TICK_BASE_LOG2)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clr_pre | reinit),
    .run  (state_q == S_RUN),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    clr_pre = 1'b0;
    reinit  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        clr_pre = 1'b1;
      end
      S_RUN: if (time_q == 4'd0) state_d = S_DONE;
      S_DONE: if (start) begin
        state_d = S_IDLE;
        reinit  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Once the timer hits zero the round is over: no more steps.
  assign run = (state_q == S_RUN) && (time_q != 4'd0);

  always_comb begin
    tick_a = tick[0];
    unique case (mode_q)
      2'd1:    tick_a = tick[1];
      2'd2:    tick_a = tick[2];
      default: tick_a = tick[0];
    endcase
  end

  assign req_a = run & tick_a;
  assign req_b = run & tick[1];
  assign slow  = run & tick[2];

  assign gnt_a = run && pend_a && (!pend_b || prio_a);
  assign gnt_b = run && pend_b && !gnt_a;

  always_comb begin
    cur     = gnt_a ? pos_a : pos_b;
    oth     = gnt_a ? pos_b : pos_a;
    cur_dir = gnt_a ? dir_a : dir_b;
    wall    = cur_dir ? |(cur & WALL_L) : |(cur & WALL_R);
    tgt     = shift_pos(cur, cur_dir);
    clash   = !wall && |(tgt & oth);
    nxt     = (wall || clash) ? cur : tgt;
    nxt_dir = (wall || clash) ? !cur_dir : cur_dir;
    pos_a_d = gnt_a ? nxt : pos_a;
    pos_b_d = gnt_b ? nxt : pos_b;
    dir_a_d = gnt_a ? nxt_dir : dir_a;
    dir_b_d = gnt_b ? nxt_dir : dir_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_a  <= A_RST;
      pos_b  <= B_RST;
      dir_a  <= 1'b0;
      dir_b  <= 1'b1;
      led_q  <= A_RST | B_RST;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      prio_a <= 1'b1;
      hits_q <= 4'd0;
      time_q <= TIME_RST;
      mode_q <= MODE_RST;
    end else if (reinit) begin
      pos_a  <= A_RST;
      pos_b  <= B_RST;
      dir_a  <= 1'b0;
      dir_b  <= 1'b1;
      led_q  <= A_RST | B_RST;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      prio_a <= 1'b1;
      hits_q <= 4'd0;
      time_q <= TIME_RST;
      mode_q <= MODE_RST;
    end else begin
      pos_a  <= pos_a_d;
      pos_b  <= pos_b_d;
      dir_a  <= dir_a_d;
      dir_b  <= dir_b_d;
      led_q  <= pos_a_d | pos_b_d;
      pend_a <= run && (req_a || (pend_a && !gnt_a));
      pend_b <= run && (req_b || (pend_b && !gnt_b));
      // Last grantee yields on the next tie.
      if (gnt_a)      prio_a <= 1'b0;
      else if (gnt_b) prio_a <= 1'b1;
      if ((gnt_a || gnt_b) && clash && hits_q != 4'hF)
        hits_q <= hits_q + 4'd1;
      if (slow) time_q <= time_q - 4'd1;
      if (state_q == S_RUN && (speed_up ^ speed_down)) begin
        if (speed_up && mode_q != MODE_MAX)
          mode_q <= mode_q + 2'd1;
        else if (speed_down && mode_q != 2'd0)
          mode_q <= mode_q - 2'd1;
      end
    end
  end

  assign led       = led_q;
  assign state     = state_q;
  assign mode_a    = mode_q;
  assign hits      = hits_q;
  assign time_left = time_q;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Scoreboard bench for snake_step_scheduler (BASE=2, ROUND_TICKS=10).
// A step-level game model pushes each expected LED bitmap; LED changes pop it.
module tb_snake_step_scheduler;

  localparam int BASE = 2;
  localparam int RT   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        speed_up = 1'b0;
  logic        speed_down = 1'b0;
  logic [15:0] led;
  logic [1:0]  state, mode_a;
  logic [3:0]  hits, time_left;

  always #5 clk = ~clk;

  snake_step_scheduler #(
    .TICK_BASE_LOG2(BASE),
    .ROUND_TICKS   (RT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .speed_up  (speed_up),
    .speed_down(speed_down),
    .led       (led),
    .state     (state),
    .mode_a    (mode_a),
    .hits      (hits),
    .time_left (time_left)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] m_a, m_b;
  logic        m_da, m_db, m_pa;
  int          m_hits, m_mode, m_time, m_c, m_state;
  logic [15:0] exp_q[$];
  logic [15:0] last_led;
  bit          mon_en = 1'b0;
  int          ncyc = 0;

  task automatic model_reset();
    m_a = 16'hE000; m_b = 16'h0001;
    m_da = 1'b0; m_db = 1'b1; m_pa = 1'b1;
    m_hits = 0; m_mode = 1; m_time = RT; m_c = 0; m_state = 0;
  endtask

  task automatic do_step(input bit is_a);
    logic [15:0] p, o, t;
    logic d, w;
    p = is_a ? m_a : m_b;
    o = is_a ? m_b : m_a;
    d = is_a ? m_da : m_db;
    w = d ? p[15] : p[0];
    t = d ? (p << 1) : (p >> 1);
    if (w) d = !d;
    else if ((t & o) != 0) begin
      d = !d;
      if (m_hits < 15) m_hits++;
    end else p = t;
    if (is_a) begin m_a = p; m_da = d; end
    else      begin m_b = p; m_db = d; end
    m_pa = !is_a;
    if (!w && (t & o) == 0) exp_q.push_back(m_a | m_b);
  endtask

  task automatic model_edge(input bit up, input bit dn, input bit st);
    bit ra, rb, sl;
    if (m_state == 0) begin
      if (st) begin m_state = 1; m_c = 0; end
    end else if (m_state == 1) begin
      if (m_time == 0) m_state = 2;
      else begin
        ra = ((m_c + 1) % (4 << m_mode)) == 0;
        rb = ((m_c + 1) % 8) == 0;
        sl = ((m_c + 1) % 16) == 0;
        if (sl) m_time--;
        if (m_time != 0) begin
          if (ra && rb) begin
            if (m_pa) begin do_step(1'b1); do_step(1'b0); end
            else      begin do_step(1'b0); do_step(1'b1); end
          end else if (ra) do_step(1'b1);
          else if (rb) do_step(1'b0);
        end
      end
      if (up && !dn && m_mode < 2) m_mode++;
      if (dn && !up && m_mode > 0) m_mode--;
      m_c++;
    end else if (st) begin
      if ((m_a | m_b) != 16'hE001) exp_q.push_back(16'hE001);
      model_reset();
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cyc(input bit up = 1'b0, input bit dn = 1'b0,
                     input bit st = 1'b0);
    speed_up = up; speed_down = dn; start = st;
    @(posedge clk);
    model_edge(up, dn, st);
    ncyc++;
    @(negedge clk);
    speed_up = 1'b0; speed_down = 1'b0; start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (led !== last_led) begin
        if (exp_q.size() == 0) chk("led_extra", 32'(led), 32'(last_led));
        else chk("led_seq", 32'(led), 32'(exp_q.pop_front()));
        last_led = led;
      end
      if (state == 2'd1) chk("popcnt", $countones(led), 4);
    end
  end

  int s0;
  logic [15:0] frz;

  initial begin
    model_reset();
    last_led = 16'hE001;
    #12;
    chk("rst_led", 32'(led), 32'hE001);
    chk("rst_state", 32'(state), 0);
    chk("rst_mode", 32'(mode_a), 1);
    chk("rst_hits", 32'(hits), 0);
    chk("rst_time", 32'(time_left), RT);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // first steps: A wins the tie, B follows next cycle
    cyc(0, 0, 1);
    s0 = ncyc;
    chk("run_state", 32'(state), 1);
    for (int i = 0; i < 9; i++) cyc();
    chk("first_a", 32'(led), 32'h7001);
    cyc();
    chk("first_b", 32'(led), 32'h7002);

    // speed mode saturation
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    chk("mode_max", 32'(mode_a), 2);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    chk("mode_min", 32'(mode_a), 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("mode_both", 32'(mode_a), 1);
    cyc(0, 1, 0);
    chk("mode_model", 32'(mode_a), 32'(m_mode));

    // play until the round ends; collisions and wall bounces en route
    for (int i = 0; i < 400 && state != 2'd2; i++) begin
      cyc();
      if (ncyc - s0 == 80) chk("time_mid", 32'(time_left), 32'(m_time));
    end
    chk("done_state", 32'(state), 2);
    chk("done_cycles", 32'(ncyc - s0), 161);
    chk("done_time", 32'(time_left), 0);
    chk("hits_model", 32'(hits), 32'(m_hits));
    chk("hits_nz", 32'(hits != 4'd0), 1);

    // frozen in DONE
    frz = led;
    cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) cyc();
    chk("done_led", 32'(led), 32'(frz));
    chk("done_mode", 32'(mode_a), 32'(m_mode));
    chk("done_state2", 32'(state), 2);

    cyc(0, 0, 1);
    chk("idle_state", 32'(state), 0);
    chk("idle_led", 32'(led), 32'hE001);
    chk("idle_time", 32'(time_left), RT);
    chk("idle_hits", 32'(hits), 0);
    chk("idle_mode", 32'(mode_a), 1);

    // async reset mid-RUN
    cyc(0, 0, 1);
    for (int i = 0; i < 30; i++) cyc();
    chk("mid_state", 32'(state), 1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_led", 32'(led), 32'hE001);
    chk("arst_state", 32'(state), 0);
    model_reset();
    exp_q.delete();
    last_led = 16'hE001;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    chk("post_rst_led", 32'(led), 32'hE001);
    chk("q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
